// File: rtl/armedf_pkg.sv
// armedf_pkg: shared constants for the sound latch / IRQ controller
package armedf_pkg;
  localparam int IRQ_DIV_DEF = 3072;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/sound_latch_fifo.sv
// sound_latch_fifo: 4-entry 68K->Z80 command FIFO; clear applies before push/pop in the same cycle
module sound_latch_fifo
  import armedf_pkg::*;
(
  input  logic  clk_sys,
  input  logic  reset,
  input  logic  clr,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t dout,
  output logic  valid
);
  byte_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail, head_c, tail_c;
  logic [PTR_W:0] cnt, cnt_c;
  logic do_pop, do_push;
  always_comb begin
    head_c = clr ? '0 : head;
    tail_c = clr ? '0 : tail;
    cnt_c = clr ? '0 : cnt;
    do_pop = pop & (cnt_c != '0);
    do_push = push & ((cnt_c != (PTR_W+1)'(FIFO_DEPTH)) | do_pop);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      head <= head_c + PTR_W'(do_pop);
      tail <= tail_c + PTR_W'(do_push);
      cnt <= cnt_c + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_sys)
    if (do_push) mem[tail_c] <= din;
  assign valid = cnt != '0;
  assign dout = valid ? mem[head] : 8'h00;
endmodule

// File: rtl/sound_irq_ctrl.sv
// sound_irq_ctrl: 68K->Z80 sound latch, Z80 periodic IRQ and 68K VBL IRQ1.
// Define SOUND_LATCH_FIFO_EN to replace the single latch with a 4-entry FIFO.
module sound_irq_ctrl
  import armedf_pkg::*;
#(
  parameter int IRQ_DIV = IRQ_DIV_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       m68k_rw,
  input  logic       m68k_lds_n,
  input  logic [7:0] m68k_din,
  input  logic       sound_latch_cs,
  input  logic       irq_ack_cs,
  input  logic       vbl,
  input  logic       z80_latch_r_cs,
  input  logic       z80_latch_clr_cs,
  input  logic       M1_n,
  input  logic       IORQ_n,
  output logic [7:0] latch_dout,
  output logic       latch_valid,
  output logic       z80_int_n,
  output logic       m68k_irq1
);
  localparam int CW = $clog2(IRQ_DIV);
  // bit order: push, read, clear, ack, vbl
  logic [4:0] cur, prev, rise;
  logic [1:0] arm;
  byte_t din_q;
  logic [CW-1:0] cnt;
  logic tc;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cur <= '0;
      prev <= '0;
      arm <= '0;
      din_q <= '0;
    end else begin
      cur <= {vbl, irq_ack_cs & ~m68k_rw, z80_latch_clr_cs, z80_latch_r_cs,
              sound_latch_cs & ~m68k_rw & ~m68k_lds_n};
      prev <= cur;
      arm <= {arm[0], 1'b1};
      din_q <= m68k_din;
    end
  end
  // arm[1] masks the first compare after reset so a level held through reset is not an edge
  assign rise = cur & ~prev & {5{arm[1]}};
  assign tc = cnt == CW'(IRQ_DIV - 1);
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
      z80_int_n <= 1'b1;
      m68k_irq1 <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      z80_int_n <= tc ? 1'b0 : (~M1_n & ~IORQ_n) ? 1'b1 : z80_int_n;
      m68k_irq1 <= rise[4] | (m68k_irq1 & ~rise[3]);
    end
  end
`ifdef SOUND_LATCH_FIFO_EN
  sound_latch_fifo u_fifo (
    .clk_sys(clk_sys),
    .reset(reset),
    .clr(rise[2]),
    .push(rise[0]),
    .pop(rise[1]),
    .din(din_q),
    .dout(latch_dout),
    .valid(latch_valid)
  );
`else
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      latch_dout <= 8'h00;
      latch_valid <= 1'b0;
    end else begin
      latch_dout <= rise[0] ? din_q : rise[2] ? 8'h00 : latch_dout;
      latch_valid <= rise[0] | (latch_valid & ~rise[2] & ~rise[1]);
    end
  end
`endif
endmodule

// File: tb/tb_sound_irq_ctrl.sv
// tb_sound_irq_ctrl: table-driven latch vectors with scoreboard plus timer, IRQ1 and reset sequences
module tb_sound_irq_ctrl;
  logic clk_sys = 0, reset = 1, m68k_rw = 1, m68k_lds_n = 1;
  logic [7:0] m68k_din = 0;
  logic sound_latch_cs = 0, irq_ack_cs = 0, vbl = 0;
  logic z80_latch_r_cs = 0, z80_latch_clr_cs = 0, M1_n = 1, IORQ_n = 1;
  logic [7:0] latch_dout;
  logic latch_valid, z80_int_n, m68k_irq1;
  int checks = 0, errors = 0;

  always #5 clk_sys = ~clk_sys;

  sound_irq_ctrl #(.IRQ_DIV(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n),
    .m68k_din(m68k_din), .sound_latch_cs(sound_latch_cs), .irq_ack_cs(irq_ack_cs),
    .vbl(vbl), .z80_latch_r_cs(z80_latch_r_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
    .M1_n(M1_n), .IORQ_n(IORQ_n), .latch_dout(latch_dout), .latch_valid(latch_valid),
    .z80_int_n(z80_int_n), .m68k_irq1(m68k_irq1)
  );

  typedef struct {
    logic wr; logic rw; logic lds_n; logic [7:0] d; logic rd; logic clr;
    logic ev; logic [7:0] ed;
  } vec_t;
  typedef struct {logic v; logic [7:0] d;} exp_t;
  exp_t sb[$];
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_bus();
    sound_latch_cs = 0; m68k_rw = 1; m68k_lds_n = 1;
    z80_latch_r_cs = 0; z80_latch_clr_cs = 0;
  endtask

  task automatic drive_push(input logic [7:0] d);
    sound_latch_cs = 1; m68k_rw = 0; m68k_lds_n = 0; m68k_din = d;
  endtask

  task automatic pulse(input vec_t t);
    @(negedge clk_sys);
    sound_latch_cs = t.wr; m68k_rw = t.rw; m68k_lds_n = t.lds_n; m68k_din = t.d;
    z80_latch_r_cs = t.rd; z80_latch_clr_cs = t.clr;
    @(negedge clk_sys);
    idle_bus();
    tick(1);
  endtask

  task automatic read_pulse();
    vec_t r;
    r = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    pulse(r);
  endtask

  initial begin
    exp_t e;
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 8'h99};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

    repeat (2) @(posedge clk_sys);
    tick(1);
    check("rst_dout", latch_dout, 8'h00);
    check("rst_valid", latch_valid, 0);
    check("rst_int_n", z80_int_n, 1);
    check("rst_irq1", m68k_irq1, 0);
    @(negedge clk_sys);
    reset = 0;

    // periodic Z80 interrupt with IRQ_DIV = 8
    tick(7);
    check("int_before_tc", z80_int_n, 1);
    tick(1);
    check("int_at_8", z80_int_n, 0);
    tick(2);
    check("int_held", z80_int_n, 0);
    @(negedge clk_sys);
    M1_n = 0; IORQ_n = 0;
    tick(1);
    check("int_ack", z80_int_n, 1);
    @(negedge clk_sys);
    M1_n = 1; IORQ_n = 1;
    tick(4);
    check("int_before_16", z80_int_n, 1);
    tick(1);
    check("int_at_16", z80_int_n, 0);
    @(negedge clk_sys);
    M1_n = 0; IORQ_n = 0;
    @(negedge clk_sys);
    M1_n = 1; IORQ_n = 1;

    // push latency: byte appears two edges after the strobe rises
    @(negedge clk_sys);
    drive_push(8'hA5);
    tick(1);
    check("push_lat1_valid", latch_valid, 0);
    @(negedge clk_sys);
    idle_bus();
    tick(1);
    check("push_lat2_valid", latch_valid, 1);
    check("push_lat2_dout", latch_dout, 8'hA5);

`ifndef SOUND_LATCH_FIFO_EN
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].ev, tbl[i].ed});
      pulse(tbl[i]);
      e = sb.pop_front();
      check($sformatf("vec%0d_valid", i), latch_valid, e.v);
      check($sformatf("vec%0d_dout", i), latch_dout, e.d);
    end
`else
    read_pulse();
    check("fifo_empty0", latch_valid, 0);
    for (int i = 1; i <= 5; i++) begin
      vec_t p;
      p = '{1'b1, 1'b0, 1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 8'h01};
      pulse(p);
    end
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fifo_rd%0d_valid", i), latch_valid, 1);
      check($sformatf("fifo_rd%0d_dout", i), latch_dout, i);
      read_pulse();
    end
    check("fifo_drained", latch_valid, 0);
    pulse(tbl[2]);
    pulse(tbl[5]);
    check("fifo_clrpush_valid", latch_valid, 1);
    check("fifo_clrpush_dout", latch_dout, 8'h3C);
    read_pulse();
    check("fifo_clrpush_single", latch_valid, 0);
`endif

    // IRQ1: set wins over a coincident ack write
    @(negedge clk_sys);
    vbl = 1; irq_ack_cs = 1; m68k_rw = 0;
    @(negedge clk_sys);
    irq_ack_cs = 0; m68k_rw = 1;
    tick(1);
    check("irq1_set_wins", m68k_irq1, 1);
    @(negedge clk_sys);
    irq_ack_cs = 1; m68k_rw = 1;
    tick(2);
    check("irq1_ack_read_ignored", m68k_irq1, 1);
    @(negedge clk_sys);
    irq_ack_cs = 0;
    @(negedge clk_sys);
    irq_ack_cs = 1; m68k_rw = 0;
    @(negedge clk_sys);
    irq_ack_cs = 0; m68k_rw = 1;
    tick(1);
    check("irq1_ack_clears", m68k_irq1, 0);
    @(negedge clk_sys);
    vbl = 0;
    tick(2);
    @(negedge clk_sys);
    vbl = 1;
    tick(1);
    check("irq1_vbl_lat1", m68k_irq1, 0);
    tick(1);
    check("irq1_vbl_set", m68k_irq1, 1);

    // reset with the push strobe and vbl held high
    @(negedge clk_sys);
    drive_push(8'hEE);
    tick(2);
    check("pre_rst_dout", latch_dout, 8'hEE);
    @(negedge clk_sys);
    reset = 1;
    tick(1);
    check("rst2_dout", latch_dout, 8'h00);
    check("rst2_valid", latch_valid, 0);
    check("rst2_int_n", z80_int_n, 1);
    check("rst2_irq1", m68k_irq1, 0);
    tick(2);
    @(negedge clk_sys);
    reset = 0;
    tick(4);
    check("post_rst_valid", latch_valid, 0);
    check("post_rst_dout", latch_dout, 8'h00);
    check("post_rst_irq1", m68k_irq1, 0);
    check("post_rst_int_n", z80_int_n, 1);
    @(negedge clk_sys);
    idle_bus();
    vbl = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
